// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master arbiter for the single-port data/instruction memory
//
// Purpose:
//   Arbitrates master 0 (instruction fetch) and master 1 (load/store) onto one
//   single-port memory. At most one request is granted per cycle. When both
//   masters request, grants are round-robin with a bounded hold window of
//   MAX_HOLD consecutive grants. Responses are registered, one cycle after
//   accept. Word addresses at or beyond MEM_NUM are granted but flagged with err.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   mX_req/we/addr/wdata         request from master X (held until mX_gnt)
//   mX_gnt                       combinational accept for master X
//   mX_rvalid/rdata/err          one-cycle registered response to master X
//   mem_rw/addr/wdata            memory drive from the granted master
//   mem_rdata                    combinational memory read data

`ifndef WRITE_ENABLE
`define WRITE_ENABLE 1'b1
`endif

module mem_arbiter #(
   parameter int MEM_NUM  = 4096,
   parameter int MAX_HOLD = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic        mem_rw,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam int          HW        = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
   localparam logic [31:0] MEM_WORDS = 32'(MEM_NUM);
   localparam logic        WR        = `WRITE_ENABLE;
   localparam logic        NWR       = ~WR;

   logic          last;
   logic [HW-1:0] hold_cnt;
   logic          gnt0, gnt1, any_gnt, sel;
   logic          sel_we, in_range;
   logic [31:0]   sel_addr, sel_wdata, resp_data;
   logic          rvalid0_q, rvalid1_q;

   // Arbitration: hold_cnt counts consecutive grants to 'last'; once it reaches
   // MAX_HOLD under contention the other master wins.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst) begin
         if (m0_req && m1_req) begin
            if (hold_cnt < HOLD_MAX) begin
               gnt0 = ~last;
               gnt1 = last;
            end else begin
               gnt0 = last;
               gnt1 = ~last;
            end
         end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
         end
      end
   end

   assign any_gnt   = gnt0 | gnt1;
   assign sel       = gnt1;
   assign sel_we    = sel ? m1_we    : m0_we;
   assign sel_addr  = sel ? m1_addr  : m0_addr;
   assign sel_wdata = sel ? m1_wdata : m0_wdata;
   assign in_range  = {2'b00, sel_addr[31:2]} < MEM_WORDS;

   assign m0_gnt    = gnt0;
   assign m1_gnt    = gnt1;
   assign mem_rw    = (any_gnt && sel_we && in_range) ? WR : NWR;
   assign mem_addr  = any_gnt ? sel_addr  : 32'd0;
   assign mem_wdata = any_gnt ? sel_wdata : 32'd0;

   // Writes and rejected accesses respond with zero data.
   assign resp_data = (sel_we || !in_range) ? 32'd0 : mem_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         last      <= 1'b0;
         hold_cnt  <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         m0_rdata  <= 32'd0;
         m1_rdata  <= 32'd0;
         m0_err    <= 1'b0;
         m1_err    <= 1'b0;
      end else begin
         rvalid0_q <= gnt0;
         rvalid1_q <= gnt1;
         if (gnt0) begin
            m0_rdata <= resp_data;
            m0_err   <= ~in_range;
         end
         if (gnt1) begin
            m1_rdata <= resp_data;
            m1_err   <= ~in_range;
         end
         if (any_gnt) begin
            if (sel == last) begin
               if (hold_cnt != HOLD_MAX)
                  hold_cnt <= hold_cnt + HW'(1);
            end else begin
               last     <= sel;
               hold_cnt <= HW'(1);
            end
         end else begin
            hold_cnt <= '0;
         end
      end
   end

   // A response in flight when reset arrives is suppressed immediately.
   assign m0_rvalid = rvalid0_q & ~rst;
   assign m1_rvalid = rvalid1_q & ~rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter

`ifndef WRITE_ENABLE
`define WRITE_ENABLE 1'b1
`endif

module tb_mem_arbiter;

   localparam int   MEM_NUM = 4096;
   localparam int   HOLD    = 4;
   localparam logic WR      = `WRITE_ENABLE;
   localparam logic NWR     = ~WR;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req [2];
   logic        we  [2];
   logic [31:0] addr[2];
   logic [31:0] wd  [2];
   logic        g0, g1, v0, v1, e0, e1, mem_rw;
   logic [31:0] q0, q1, mem_addr, mem_wdata, mem_rdata;

   mem_arbiter #(.MEM_NUM(MEM_NUM), .MAX_HOLD(HOLD)) dut (
      .clk(clk), .rst(rst),
      .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wd[0]),
      .m0_gnt(g0), .m0_rvalid(v0), .m0_rdata(q0), .m0_err(e0),
      .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wd[1]),
      .m1_gnt(g1), .m1_rvalid(v1), .m1_rdata(q1), .m1_err(e1),
      .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Second instance with MAX_HOLD=1, both masters requesting constantly.
   logic        a_req = 1'b1, a_we = 1'b0;
   logic [31:0] a_zero = 32'd0;
   logic        ag0, ag1, av0, av1, ae0, ae1, a_rw;
   logic [31:0] aq0, aq1, a_maddr, a_mwdata;

   mem_arbiter #(.MEM_NUM(MEM_NUM), .MAX_HOLD(1)) dut_alt (
      .clk(clk), .rst(rst),
      .m0_req(a_req), .m0_we(a_we), .m0_addr(a_zero), .m0_wdata(a_zero),
      .m0_gnt(ag0), .m0_rvalid(av0), .m0_rdata(aq0), .m0_err(ae0),
      .m1_req(a_req), .m1_we(a_we), .m1_addr(a_zero), .m1_wdata(a_zero),
      .m1_gnt(ag1), .m1_rvalid(av1), .m1_rdata(aq1), .m1_err(ae1),
      .mem_rw(a_rw), .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_rdata(a_zero)
   );

   // Memory seen by the DUT: combinational read, write on posedge.
   logic [31:0] mem [0:MEM_NUM-1];
   assign mem_rdata = mem[mem_addr[13:2]];
   always @(posedge clk)
      if (mem_rw == WR) mem[mem_addr[13:2]] <= mem_wdata;

   // ---------------- reference model ----------------
   logic [31:0] ref_mem [0:MEM_NUM-1];
   int          hist[$];           // granted master per cycle since reset, -1 = none
   logic        x_v[2], x_e[2], acc[2];
   logic [31:0] x_q[2];
   int          checks = 0;
   int          errors = 0;

   function automatic int model_grant();
      int lst, run;
      lst = 0;
      run = 0;
      for (int i = hist.size() - 1; i >= 0; i--)
         if (hist[i] >= 0) begin lst = hist[i]; break; end
      for (int i = hist.size() - 1; i >= 0; i--) begin
         if (hist[i] != lst) break;
         run++;
      end
      if (rst) return -1;
      if (req[0] && req[1]) return (run < HOLD) ? lst : 1 - lst;
      if (req[0]) return 0;
      if (req[1]) return 1;
      return -1;
   endfunction

   function automatic logic in_rng(logic [31:0] a);
      return int'(a[31:2]) < MEM_NUM;
   endfunction

   task automatic model_update();
      int g;
      g = model_grant();
      acc[0] = (g == 0);
      acc[1] = (g == 1);
      if (rst) begin
         hist.delete();
         for (int m = 0; m < 2; m++) begin x_v[m] = 0; x_e[m] = 0; x_q[m] = 0; end
      end else begin
         x_v[0] = 0;
         x_v[1] = 0;
         if (g >= 0) begin
            x_v[g] = 1;
            x_e[g] = ~in_rng(addr[g]);
            x_q[g] = (we[g] || !in_rng(addr[g])) ? 32'd0 : ref_mem[addr[g][13:2]];
            if (we[g] && in_rng(addr[g])) ref_mem[addr[g][13:2]] = wd[g];
         end
         hist.push_back(g);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic set_req(int m, logic r, logic w, logic [31:0] a, logic [31:0] d);
      req[m] = r; we[m] = w; addr[m] = a; wd[m] = d;
   endtask

   function automatic logic [29:0] pick_word();
      case ($urandom % 10)
         8:       return 30'd4096;
         9:       return 30'h3FFF_FFFF;
         default: return 30'($urandom % 8);
      endcase
   endfunction

   // ---------------- directed vector table ----------------
   typedef struct {
      logic rst;
      logic r0, w0; logic [31:0] a0, d0;
      logic r1, w1; logic [31:0] a1, d1;
      logic g0, g1, wr;
      logic v0; logic [31:0] q0; logic e0;
      logic v1; logic [31:0] q1; logic e1;
   } vec_t;

   vec_t tv[10];

   initial begin
      for (int i = 0; i < MEM_NUM; i++) begin mem[i] = 0; ref_mem[i] = 0; end
      for (int m = 0; m < 2; m++) set_req(m, 0, 0, 0, 0);

      //        rst r0 w0 a0        d0            r1 w1 a1     d1            g0 g1 wr v0 q0            e0 v1 q1            e1
      tv[0] = '{1, 1, 1, 32'h0,    32'hAAAA_AAAA, 1, 1, 32'h4, 32'hBBBB_BBBB, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0};
      tv[1] = '{0, 1, 0, 32'h0,    32'h0,         1, 0, 32'h0, 32'h0,         1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0};
      tv[2] = '{0, 0, 0, 32'h0,    32'h0,         1, 1, 32'h10,32'hDEAD_BEEF, 0, 1, 1, 1, 32'h0,        0, 0, 32'h0,        0};
      tv[3] = '{0, 0, 0, 32'h0,    32'h0,         1, 0, 32'h10,32'h0,         0, 1, 0, 0, 32'h0,        0, 1, 32'h0,        0};
      tv[4] = '{0, 0, 0, 32'h0,    32'h0,         0, 0, 32'h0, 32'h0,         0, 0, 0, 0, 32'h0,        0, 1, 32'hDEAD_BEEF,0};
      tv[5] = '{0, 1, 1, 32'h4000, 32'h1234_5678, 0, 0, 32'h0, 32'h0,         1, 0, 0, 0, 32'h0,        0, 0, 32'hDEAD_BEEF,0};
      tv[6] = '{0, 1, 0, 32'h0,    32'h0,         0, 0, 32'h0, 32'h0,         1, 0, 0, 1, 32'h0,        1, 0, 32'hDEAD_BEEF,0};
      tv[7] = '{0, 0, 0, 32'h0,    32'h0,         0, 0, 32'h0, 32'h0,         0, 0, 0, 1, 32'h0,        0, 0, 32'hDEAD_BEEF,0};
      tv[8] = '{0, 1, 0, 32'h12,   32'h0,         0, 0, 32'h0, 32'h0,         1, 0, 0, 0, 32'h0,        0, 0, 32'hDEAD_BEEF,0};
      tv[9] = '{0, 0, 0, 32'h0,    32'h0,         0, 0, 32'h0, 32'h0,         0, 0, 0, 1, 32'hDEAD_BEEF,0, 0, 32'hDEAD_BEEF,0};

      rst = 1;
      repeat (2) tick();

      for (int i = 0; i < 10; i++) begin
         rst = tv[i].rst;
         set_req(0, tv[i].r0, tv[i].w0, tv[i].a0, tv[i].d0);
         set_req(1, tv[i].r1, tv[i].w1, tv[i].a1, tv[i].d1);
         @(negedge clk);
         chk($sformatf("row%0d_g0", i), g0, tv[i].g0);
         chk($sformatf("row%0d_g1", i), g1, tv[i].g1);
         chk($sformatf("row%0d_rw", i), mem_rw, tv[i].wr ? WR : NWR);
         chk($sformatf("row%0d_v0", i), v0, tv[i].v0);
         chk($sformatf("row%0d_q0", i), q0, tv[i].q0);
         chk($sformatf("row%0d_e0", i), e0, tv[i].e0);
         chk($sformatf("row%0d_v1", i), v1, tv[i].v1);
         chk($sformatf("row%0d_q1", i), q1, tv[i].q1);
         chk($sformatf("row%0d_e1", i), e1, tv[i].e1);
         tick();
      end

      // Contention from reset: MAX_HOLD=4 gives runs of 4, MAX_HOLD=1 alternates.
      rst = 1;
      set_req(0, 1, 0, 32'h0, 0);
      set_req(1, 1, 0, 32'h4, 0);
      tick();
      rst = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk($sformatf("cont%0d_g0", i), g0, ((i / 4) % 2) == 0);
         chk($sformatf("cont%0d_g1", i), g1, ((i / 4) % 2) == 1);
         chk($sformatf("alt%0d_g0", i), ag0, (i % 2) == 0);
         chk($sformatf("alt%0d_g1", i), ag1, (i % 2) == 1);
         tick();
      end

      // Reset one cycle after a read is accepted drops the response.
      set_req(0, 0, 0, 32'h0, 0);
      set_req(1, 1, 0, 32'h10, 0);
      @(negedge clk);
      chk("midrst_accept_g1", g1, 1);
      tick();
      rst = 1;
      set_req(1, 0, 0, 32'h0, 0);
      @(negedge clk);
      chk("midrst_v1_in_rst", v1, 0);
      tick();
      rst = 0;
      @(negedge clk);
      chk("midrst_v1_after", v1, 0);
      chk("midrst_q1_after", q1, 0);
      chk("midrst_e1_after", e1, 0);
      chk("midrst_v0_after", v0, 0);
      chk("midrst_q0_after", q0, 0);
      tick();
      set_req(0, 1, 0, 32'h0, 0);
      set_req(1, 1, 0, 32'h0, 0);
      @(negedge clk);
      chk("midrst_last0_g0", g0, 1);
      chk("midrst_last0_g1", g1, 0);
      tick();

      // Randomized traffic against the reference model.
      rst = 1;
      tick();
      rst = 0;
      for (int c = 0; c < 400; c++) begin
         int eg;
         for (int m = 0; m < 2; m++)
            if (!req[m] || acc[m])
               set_req(m, ($urandom % 3) != 0, $urandom % 2,
                       {pick_word(), 2'($urandom)}, $urandom);
         @(negedge clk);
         eg = model_grant();
         chk("rnd_g0", g0, eg == 0);
         chk("rnd_g1", g1, eg == 1);
         chk("rnd_rw", mem_rw,
             (eg >= 0 && we[eg] && in_rng(addr[eg])) ? WR : NWR);
         chk("rnd_addr", mem_addr, (eg >= 0) ? addr[eg] : 32'd0);
         chk("rnd_wdata", mem_wdata, (eg >= 0) ? wd[eg] : 32'd0);
         chk("rnd_v0", v0, x_v[0]);
         chk("rnd_v1", v1, x_v[1]);
         chk("rnd_q0", q0, x_q[0]);
         chk("rnd_q1", q1, x_q[1]);
         chk("rnd_e0", e0, x_e[0]);
         chk("rnd_e1", e1, x_e[1]);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
